// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and are
// serialized on UART_TX back-to-back, LSB first.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 12000000,
    parameter int UART_BAUD  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          ICE_CLK,
    input  logic                          RST_N,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          UART_TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop, baud_last;

    assign full      = (fifo_count == FULL_COUNT);
    assign empty     = (fifo_count == '0);
    assign wr_ready  = !full;
    assign push      = wr_valid && wr_ready;
    assign overflow  = wr_valid && !wr_ready;
    assign busy      = (state_q != IDLE) || !empty;
    assign UART_TX   = tx_q;
    assign baud_last = (baud_q == BAUD_LAST);

    // Storage has no reset; occupancy is tracked by the counter, not the data.
    always_ff @(posedge ICE_CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The shift register moves right each data bit, so shift_q[0] is always
    // the bit on the line and shift_q[1] the next one.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 16 clocks per bit: reset, single frame,
// back-to-back burst, overflow with full-depth drain, and reset mid-frame.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       ICE_CLK = 1'b0;
    logic       RST_N;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       UART_TX;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_fifo #(
        .CLK_FREQ   (16),
        .UART_BAUD  (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ICE_CLK    (ICE_CLK),
        .RST_N      (RST_N),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .UART_TX    (UART_TX),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 ICE_CLK = ~ICE_CLK;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge ICE_CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves wr_valid high; the caller decides when to drop it.
    task automatic applyStimulus(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        tick();
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " tx"},       UART_TX,    1);
        checkOutput({tag, " wr_ready"}, wr_ready,   1);
        checkOutput({tag, " busy"},     busy,       0);
        checkOutput({tag, " count"},    fifo_count, 0);
        checkOutput({tag, " overflow"}, overflow,   0);
    endtask

    // Called `skip` cycles into the start bit; checks first/last cycle of every
    // bit and the occupancy seen on the last stop cycle (before any pop).
    task automatic checkFrame(input logic [7:0] d, input int cnt_end, input int skip);
        logic ebit;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      ebit = 1'b0;
            else if (b == 9) ebit = 1'b1;
            else             ebit = d[b-1];
            if (b != 0 || skip == 0)
                checkOutput($sformatf("frame %02h bit%0d first", d, b), UART_TX, ebit);
            repeat (CPB - 1 - ((b == 0) ? skip : 0)) tick();
            checkOutput($sformatf("frame %02h bit%0d last", d, b), UART_TX, ebit);
            if (b == 9) begin
                checkOutput($sformatf("frame %02h busy stop", d), busy, 1);
                checkOutput($sformatf("frame %02h count stop", d), fifo_count, cnt_end);
            end
            tick();
        end
    endtask

    initial begin
        RST_N    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        repeat (3) tick();
        checkIdle("por");
        RST_N = 1'b1;
        tick();
        checkIdle("por release");

        // Reset asserted during a start bit must return the line high at once.
        applyStimulus(8'h81);
        wr_valid = 1'b0;
        tick();
        checkOutput("s1 start low", UART_TX, 0);
        repeat (5) tick();
        #2;
        RST_N = 1'b0;
        #1;
        checkIdle("s1 async");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkIdle("s1 held");
        end
        RST_N = 1'b1;
        tick();
        checkIdle("s1 release");
        repeat (CPB) tick();
        checkIdle("s1 after");

        // Single byte: start bit appears one edge after acceptance.
        applyStimulus(8'hA5);
        wr_valid = 1'b0;
        checkOutput("s2 tx before start", UART_TX, 1);
        checkOutput("s2 count queued", fifo_count, 1);
        checkOutput("s2 busy queued", busy, 1);
        tick();
        checkOutput("s2 count popped", fifo_count, 0);
        checkFrame(8'hA5, 0, 0);
        checkOutput("s2 busy end", busy, 0);
        checkOutput("s2 tx end", UART_TX, 1);

        // Burst of three: frames abut with no idle between stop and start.
        repeat (4) tick();
        applyStimulus(8'h55);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        wr_valid = 1'b0;
        checkOutput("s3 count", fifo_count, 2);
        checkFrame(8'h55, 2, 1);
        checkFrame(8'h00, 1, 0);
        checkFrame(8'hFF, 0, 0);
        checkOutput("s3 busy end", busy, 0);
        checkOutput("s3 tx end", UART_TX, 1);

        // Overflow: 18 consecutive writes, the last one rejected.
        repeat (4) tick();
        for (int i = 0; i < 18; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            #1;
            if (i == 17) begin
                checkOutput("s4 wr_ready full", wr_ready, 0);
                checkOutput("s4 overflow pulse", overflow, 1);
                checkOutput("s4 count full", fifo_count, DEPTH);
            end else begin
                checkOutput($sformatf("s4 overflow quiet %0d", i), overflow, 0);
            end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        checkOutput("s4 overflow cleared", overflow, 0);
        checkOutput("s4 count kept", fifo_count, DEPTH);
        repeat (143) tick();
        checkOutput("s4 frame0 stop", UART_TX, 1);
        tick();
        for (int k = 1; k <= 16; k++) begin
            checkFrame(8'(k), DEPTH - k, 0);
        end
        checkOutput("s4 busy end", busy, 0);
        checkOutput("s4 tx end", UART_TX, 1);

        // Reset in data bit 3 of 0x3C with two bytes still queued.
        repeat (4) tick();
        applyStimulus(8'h3C);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        wr_valid = 1'b0;
        checkOutput("s5 count", fifo_count, 2);
        repeat (68) tick();
        checkOutput("s5 bit3", UART_TX, 1);
        #2;
        RST_N = 1'b0;
        #1;
        checkIdle("s5 async");
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
        checkIdle("s5 release");
        applyStimulus(8'hC3);
        wr_valid = 1'b0;
        tick();
        checkFrame(8'hC3, 0, 0);
        checkIdle("s5 end");
        repeat (CPB) tick();
        checkIdle("s5 quiet");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter (8N1), the transmit-side counterpart to uart_rx.
- Accepts bytes over a valid/ready handshake into an internal FIFO and serializes them on UART_TX back-to-back.
- Lets upstream logic (echo paths, status reporters) burst bytes without polling a tx_done line.
- Sits between fabric logic and the board UART_TX pin.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz.
- UART_BAUD, 9600, line rate in baud.
- FIFO_DEPTH, 16, byte entries. Must be a power of 2, minimum 2.

Ports:
- ICE_CLK  input  1  system clock; all state on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- wr_data  input  8  byte to enqueue.
- wr_valid  input  1  wr_data valid this cycle.
- wr_ready  output  1  FIFO can accept; high when FIFO not full.
- UART_TX  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  one-cycle pulse when wr_valid is high and wr_ready is low.

Behaviour:
- Bit period: CLKS_PER_BIT = CLK_FREQ/UART_BAUD, integer truncation. Default is 1250.
  - Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- Reset (RST_N low, asynchronous):
  - UART_TX=1, wr_ready=1, busy=0, fifo_count=0, overflow=0.
  - FIFO emptied, FSM in IDLE, baud and bit counters cleared.
  - A frame in flight is abandoned and UART_TX goes high immediately. Bytes in the FIFO are discarded.
- Write handshake:
  - A byte is accepted on the rising edge where wr_valid && wr_ready.
  - The write is decided from wr_ready alone: when full, a write is rejected even if a pop occurs on the same edge.
  - A rejected write pulses overflow for that one cycle and leaves FIFO contents unchanged.
- FIFO:
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - fifo_count is a separate counter: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - full is fifo_count==FIFO_DEPTH; empty is fifo_count==0.
- FSM states: IDLE, START, DATA, STOP. UART_TX is a registered output.
  - IDLE: UART_TX=1. On an edge where the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START, UART_TX=0.
  - Latency: a byte accepted into an empty FIFO on edge N drives UART_TX low after edge N+1.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift bits LSB first, each for CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. On its last cycle:
    - FIFO non-empty: pop and go directly to START, with no idle gap between frames.
    - FIFO empty: go to IDLE.
  - The FSM never pops when the FIFO is empty. A write arriving on the same edge that an IDLE FSM samples empty is transmitted starting on the next edge.
- Derived outputs:
  - Frame length is 10*CLKS_PER_BIT cycles.
  - busy = (state != IDLE) || (fifo_count != 0), combinational.
  - wr_ready = !full, combinational.

Test Plan:
- Bench parameters are CLK_FREQ=16, UART_BAUD=1 (16 clks/bit, 160-cycle frame) and FIFO_DEPTH=16, except scenario 6.
1. Reset: assert RST_N low mid-run -> UART_TX=1, wr_ready=1, busy=0, fifo_count=0, overflow=0 while held low and on release.
2. Single byte 0xA5 written on edge N -> UART_TX low after edge N+1 for 16 cycles, then data 1,0,1,0,0,1,0,1 at 16 cycles each, then stop high for 16 cycles. busy deasserts exactly 160 cycles after the start edge.
3. Burst 0x55,0x00,0xFF on consecutive cycles -> three frames totalling 480 cycles with no idle high between the stop and next start bits. fifo_count reads 2, then 1, then 0 at the frame boundaries.
4. Overflow: wr_valid held for 18 consecutive cycles from idle -> bytes 0..16 accepted (byte 0 popped immediately). On the 18th cycle wr_ready=0, overflow pulses once, fifo_count=16. All 17 bytes later appear in order on the line.
5. Reset mid-frame during data bit 3 of 0x3C with 2 bytes queued -> UART_TX=1 at once and fifo_count=0. A new write of 0xC3 after release produces one clean 0xC3 frame.
6. Loopback at default parameters into uart_rx #(.UART_BAUD(9600)): stream bytes 0x00..0xFF through the FIFO -> receiver reports all 256 bytes in order with no loss.
